// File: rtl/adder_arb_ctrl.sv
// Round-robin arbiter sharing one 16-bit adder between two requesters.
// Define ADDER_ARB_STATS_EN to build op_count / ovf_sticky statistics.

module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        overflow
);

  // overflow is two's-complement: same-sign inputs, different-sign sum
  always_comb begin
    sum      = a + b + {15'b0, cin};
    overflow = (a[15] == b[15]) && (sum[15] != a[15]);
  end

endmodule

module adder_arb_ctrl #(
  parameter int ADD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_cin,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_cin,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic [15:0] resp_sum,
  output logic        resp_overflow,
  output logic        resp_id,
  input  logic        resp_ready,
  output logic [7:0]  op_count,
  output logic        ovf_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(ADD_LAT - 1);

  state_t      state;
  state_t      next;
  logic        last_grant;
  logic        grant0;
  logic        grant1;
  logic        accept;
  logic [1:0]  cnt;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        op_cin;
  logic        op_id;
  logic [15:0] add_sum;
  logic        add_ovf;

  adder_16bit u_add (
    .a        (op_a),
    .b        (op_b),
    .cin      (op_cin),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    next   = state;
    unique case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant0 = last_grant;
          grant1 = !last_grant;
        end else begin
          grant0 = req0_valid;
          grant1 = req1_valid;
        end
        if (grant0 || grant1) next = SETTLE;
      end
      SETTLE: if (cnt == 2'd0) next = RESP;
      RESP:   if (resp_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  assign accept     = grant0 || grant1;
  assign req0_ready = grant0 && !rst;
  assign req1_ready = grant1 && !rst;
  assign resp_valid = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= 1'b1;
      cnt           <= 2'd0;
      op_a          <= 16'h0;
      op_b          <= 16'h0;
      op_cin        <= 1'b0;
      op_id         <= 1'b0;
      resp_sum      <= 16'h0;
      resp_overflow <= 1'b0;
      resp_id       <= 1'b0;
    end else begin
      if (accept) begin
        op_a       <= grant1 ? req1_a : req0_a;
        op_b       <= grant1 ? req1_b : req0_b;
        op_cin     <= grant1 ? req1_cin : req0_cin;
        op_id      <= grant1;
        last_grant <= grant1;
        cnt        <= LAT_M1;
      end
      if (state == SETTLE) begin
        if (cnt == 2'd0) begin
          resp_sum      <= add_sum;
          resp_overflow <= add_ovf;
          resp_id       <= op_id;
        end else begin
          cnt <= cnt - 2'd1;
        end
      end
    end
  end

`ifdef ADDER_ARB_STATS_EN
  logic [7:0] cnt_q;
  logic       stk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'h0;
      stk_q <= 1'b0;
    end else if (resp_valid && resp_ready) begin
      cnt_q <= cnt_q + 8'h1;
      if (resp_overflow) stk_q <= 1'b1;
    end
  end

  assign op_count   = cnt_q;
  assign ovf_sticky = stk_q;
`else
  assign op_count   = 8'h0;
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_adder_arb_ctrl.sv
// Scoreboard bench for adder_arb_ctrl: accepts push expectations,
// a monitor pops and compares on every response handshake.

module tb_adder_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic [15:0] req0_a = '0;
  logic [15:0] req0_b = '0;
  logic        req0_cin = 1'b0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [15:0] req1_a = '0;
  logic [15:0] req1_b = '0;
  logic        req1_cin = 1'b0;
  logic        req1_ready;
  logic        resp_valid;
  logic [15:0] resp_sum;
  logic        resp_overflow;
  logic        resp_id;
  logic        resp_ready = 1'b1;
  logic [7:0]  op_count;
  logic        ovf_sticky;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs = 0;
  logic stk = 1'b0;

  // expected {id, ovf, sum} per requester, set by the stimulus
  logic [15:0] e_sum0, e_sum1;
  logic        e_ovf0, e_ovf1;
  logic [17:0] sb[$];

  adder_arb_ctrl #(.ADD_LAT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0_valid    (req0_valid),
    .req0_a        (req0_a),
    .req0_b        (req0_b),
    .req0_cin      (req0_cin),
    .req0_ready    (req0_ready),
    .req1_valid    (req1_valid),
    .req1_a        (req1_a),
    .req1_b        (req1_b),
    .req1_cin      (req1_cin),
    .req1_ready    (req1_ready),
    .resp_valid    (resp_valid),
    .resp_sum      (resp_sum),
    .resp_overflow (resp_overflow),
    .resp_id       (resp_id),
    .resp_ready    (resp_ready),
    .op_count      (op_count),
    .ovf_sticky    (ovf_sticky)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (req0_valid && req0_ready) sb.push_back({1'b0, e_ovf0, e_sum0});
      if (req1_valid && req1_ready) sb.push_back({1'b1, e_ovf1, e_sum1});
    end
  end

  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      logic [17:0] e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got %0h expected none",
                 {resp_id, resp_overflow, resp_sum});
      end else begin
        e = sb.pop_front();
        if ({resp_id, resp_overflow, resp_sum} !== e) begin
          errors++;
          $display("FAIL resp_data: got %0h expected %0h",
                   {resp_id, resp_overflow, resp_sum}, e);
        end
        hs++;
        if (e[16]) stk = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    hs = 0;
    stk = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_accept(output int id, output int c);
    bit got = 0;
    id = -1;
    c = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (req0_valid && req0_ready) begin id = 0; got = 1; end
      else if (req1_valid && req1_ready) begin id = 1; got = 1; end
      c = cyc;
    end
    if (!got) chk("accept_timeout", 0, 1);
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", sb.size(), 0);
    tick();
  endtask

  task automatic chk_stats(input string name);
`ifdef ADDER_ARB_STATS_EN
    chk({name, "_cnt"}, int'(op_count), hs % 256);
    chk({name, "_stk"}, int'(ovf_sticky), int'(stk));
`else
    chk({name, "_cnt"}, int'(op_count), 0);
    chk({name, "_stk"}, int'(ovf_sticky), 0);
`endif
  endtask

  initial begin
    int id, c, pc, n;
    // reset state, with valids high to show readies are held low
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_rv", int'(resp_valid), 0);
    chk("rst_r0", int'(req0_ready), 0);
    chk("rst_r1", int'(req1_ready), 0);
    chk("rst_sum", int'(resp_sum), 0);
    chk("rst_ovf", int'(resp_overflow), 0);
    chk_stats("rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // single request, latency check
    req0_a = 16'h1234; req0_b = 16'h0001; req0_cin = 1'b1;
    e_sum0 = 16'h1236; e_ovf0 = 1'b0;
    req0_valid = 1'b1;
    @(negedge clk);
    chk("t1_r0", int'(req0_ready), 1);
    chk("t1_r1", int'(req1_ready), 0);
    tick();
    req0_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    chk("t1_lat", n, 3);
    drain();

    // both requesters continuously: alternating grants every 4 cycles
    do_reset();
    req0_a = 16'h0001; req0_b = 16'h0002; req0_cin = 1'b0;
    e_sum0 = 16'h0003; e_ovf0 = 1'b0;
    req1_a = 16'h0010; req1_b = 16'h0020; req1_cin = 1'b1;
    e_sum1 = 16'h0031; e_ovf1 = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    pc = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(id, c);
      chk("t2_grant", id, k % 2);
      if (k > 0) chk("t2_gap", c - pc, 4);
      pc = c;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // signed overflow and statistics
    do_reset();
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b0;
    e_sum0 = 16'h8000; e_ovf0 = 1'b1;
    req0_valid = 1'b1;
    wait_accept(id, c);
    req0_valid = 1'b0;
    drain();
    chk_stats("t3");

    // backpressure with req1 pending
    resp_ready = 1'b0;
    req0_a = 16'h0100; req0_b = 16'h0200; req0_cin = 1'b0;
    e_sum0 = 16'h0300; e_ovf0 = 1'b0;
    req1_a = 16'h0005; req1_b = 16'h0003; req1_cin = 1'b1;
    e_sum1 = 16'h0009; e_ovf1 = 1'b0;
    req0_valid = 1'b1;
    wait_accept(id, c);
    chk("t4_first", id, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_rv", int'(resp_valid), 1);
      chk("t4_sum", int'(resp_sum), 16'h0300);
      chk("t4_r1", int'(req1_ready), 0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t4_r1_idle", int'(req1_ready), 1);
    tick();
    req1_valid = 1'b0;
    drain();
    chk_stats("t4");

    // reset during settle discards the operation
    req0_a = 16'h0042; req0_b = 16'h0001; req0_cin = 1'b0;
    e_sum0 = 16'h0043; e_ovf0 = 1'b0;
    req0_valid = 1'b1;
    wait_accept(id, c);
    req0_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    hs = 0;
    stk = 1'b0;
    #1;
    chk("t5_rv_async", int'(resp_valid), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_rv", int'(resp_valid), 0);
    end
    tick();
    req0_a = 16'h0002; req0_b = 16'h0002; req0_cin = 1'b0;
    e_sum0 = 16'h0004; e_ovf0 = 1'b0;
    req1_a = 16'h0003; req1_b = 16'h0003; req1_cin = 1'b0;
    e_sum1 = 16'h0006; e_ovf1 = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    wait_accept(id, c);
    chk("t5_grant", id, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // operands changing after accept are ignored
    req0_a = 16'h1000; req0_b = 16'h0234; req0_cin = 1'b0;
    e_sum0 = 16'h1234; e_ovf0 = 1'b0;
    req0_valid = 1'b1;
    wait_accept(id, c);
    req0_valid = 1'b0;
    req0_a = 16'hFFFF;
    req0_b = 16'hFFFF;
    req0_cin = 1'b1;
    drain();
    chk_stats("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
